// File: rtl/zephyr.sv
// zephyr: 8-bit three-state (fetch/decode/execute) accumulator-style core with 16x8 unified RAM.
// Optional feature macro ZEPHYR_JMP_EN: opcode 11 is JMP; without it opcode 11 executes as NOP.

module zephyr_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    // Contents deliberately survive reset so benches can preload the program.
    logic [7:0] registers [0:15];

    assign rdata = registers[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            registers[addr] <= wdata;
        end
    end

endmodule

module zephyr (
    input logic CLK,
    input logic RESET
);

    typedef enum logic [1:0] {
        StFetch   = 2'b00,
        StDecode  = 2'b01,
        StExecute = 2'b10
    } state_e;

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;
    localparam logic [1:0] OpJmp   = 2'b11;

    state_e     zstate;
    logic [3:0] PC;
    logic [7:0] IR;
    logic [3:0] RAM_ADDR;
    logic [7:0] R0, R1, R2, R3;

    logic [1:0] opcode;
    logic [1:0] rd_idx;
    logic [3:0] imm;
    logic [7:0] mem_rdata;
    logic [7:0] rd_val;
    logic       mem_we;

    assign opcode = IR[7:6];
    assign rd_idx = IR[5:4];
    assign imm    = IR[3:0];

    always_comb begin
        rd_val = R0;
        case (rd_idx)
            2'd0:    rd_val = R0;
            2'd1:    rd_val = R1;
            2'd2:    rd_val = R2;
            default: rd_val = R3;
        endcase
    end

    // RAM_ADDR already holds A during execute, so the store address needs no extra mux.
    assign mem_we = (zstate == StExecute) && (opcode == OpStore);

    zephyr_ram ram_inst (
        .clk   (CLK),
        .we    (mem_we),
        .addr  (RAM_ADDR),
        .wdata (rd_val),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            zstate   <= StFetch;
            PC       <= 4'd0;
            IR       <= 8'h00;
            RAM_ADDR <= 4'd0;
            R0       <= 8'h00;
            R1       <= 8'h00;
            R2       <= 8'h00;
            R3       <= 8'h00;
        end else begin
            case (zstate)
                StFetch: begin
                    IR     <= mem_rdata;
                    PC     <= PC + 4'd1;
                    zstate <= StDecode;
                end
                StDecode: begin
                    if (opcode == OpLoad || opcode == OpStore) begin
                        RAM_ADDR <= imm;
                    end else begin
                        RAM_ADDR <= PC;
                    end
                    zstate <= StExecute;
                end
                StExecute: begin
                    RAM_ADDR <= PC;
                    case (opcode)
                        OpLoad: begin
                            case (rd_idx)
                                2'd0:    R0 <= mem_rdata;
                                2'd1:    R1 <= mem_rdata;
                                2'd2:    R2 <= mem_rdata;
                                default: R3 <= mem_rdata;
                            endcase
                        end
`ifdef ZEPHYR_JMP_EN
                        OpJmp: begin
                            PC       <= imm;
                            RAM_ADDR <= imm;
                        end
`endif
                        default: ;
                    endcase
                    zstate <= StFetch;
                end
                default: zstate <= StFetch;
            endcase
        end
    end

    // Opcode constants kept for readability even where a build does not decode them.
    logic unused_ops;
    assign unused_ops = ^{OpNop, OpJmp};

endmodule

// File: tb/tb_zephyr.sv
// Self-checking bench for zephyr: directed vector table, hand-written corner sequences,
// and random programs checked against an instruction-level reference interpreter.

module tb_zephyr;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    zephyr dut (
        .CLK   (CLK),
        .RESET (RESET)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] img [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Hold reset for two cycles, preload RAM while the core is idle, release between edges.
    task automatic load_and_release();
        RESET = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        for (int i = 0; i < 16; i++) dut.ram_inst.registers[i] = img[i];
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    function automatic logic [7:0] reg_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return dut.R0;
            2'd1:    return dut.R1;
            2'd2:    return dut.R2;
            default: return dut.R3;
        endcase
    endfunction

    function automatic void clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endfunction

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
        logic [3:0] fa;
        logic [7:0] fv;
        logic [1:0] creg;
        logic [7:0] ereg;
        logic [3:0] caddr;
        logic [7:0] emem;
        logic [3:0] epc;
    } vec_t;

    vec_t vecs [5];

    // Reference interpreter state
    logic [7:0] m [16];
    logic [7:0] r [4];
    logic [3:0] mpc;

    function automatic void model_step();
        logic [7:0] ins;
        ins = m[mpc];
        mpc = mpc + 4'd1;
        case (ins[7:6])
            2'b01: r[ins[5:4]] = m[ins[3:0]];
            2'b10: m[ins[3:0]] = r[ins[5:4]];
`ifdef ZEPHYR_JMP_EN
            2'b11: mpc = ins[3:0];
`endif
            default: ;
        endcase
    endfunction

    initial begin
        vecs[0] = '{8'h4F, 8'h00, 4'hF, 8'hFF, 2'd0, 8'hFF, 4'hF, 8'hFF, 4'd2};
        vecs[1] = '{8'h7E, 8'hBD, 4'hE, 8'h5A, 2'd3, 8'h5A, 4'hD, 8'h5A, 4'd2};
        vecs[2] = '{8'h69, 8'hA1, 4'h9, 8'hA5, 2'd2, 8'hA5, 4'h1, 8'hA5, 4'd2};
`ifdef ZEPHYR_JMP_EN
        vecs[3] = '{8'hC5, 8'h00, 4'h5, 8'h55, 2'd1, 8'h55, 4'h5, 8'h55, 4'd6};
`else
        vecs[3] = '{8'hC5, 8'h00, 4'h5, 8'h55, 2'd1, 8'h00, 4'h5, 8'h55, 4'd2};
`endif
        vecs[4] = '{8'h81, 8'h4F, 4'hF, 8'hFF, 2'd0, 8'h00, 4'h1, 8'h00, 4'd2};

        // Reset state
        RESET = 1'b0;
        edges(2);
        chk("reset_pc", 32'(dut.PC), 32'h0);
        chk("reset_ir", 32'(dut.IR), 32'h00);
        chk("reset_ram_addr", 32'(dut.RAM_ADDR), 32'h0);
        chk("reset_state", 32'(dut.zstate), 32'h0);
        chk("reset_regs", {dut.R3, dut.R2, dut.R1, dut.R0}, 32'h0);

        // LOAD scenario, edge by edge
        clear_img();
        img[1] = 8'h4F; img[2] = 8'h33; img[3] = 8'h3F; img[15] = 8'hFF;
        load_and_release();
        edges(1);
        chk("load_e1_ir", 32'(dut.IR), 32'h00);
        chk("load_e1_pc", 32'(dut.PC), 32'h1);
        chk("load_e1_state", 32'(dut.zstate), 32'h1);
        edges(1);
        chk("load_e2_state", 32'(dut.zstate), 32'h2);
        edges(1);
        chk("load_e3_state", 32'(dut.zstate), 32'h0);
        edges(1);
        chk("load_e4_ir", 32'(dut.IR), 32'h4F);
        chk("load_e4_pc", 32'(dut.PC), 32'h2);
        edges(1);
        chk("load_e5_ram_addr", 32'(dut.RAM_ADDR), 32'hF);
        edges(1);
        chk("load_e6_r0", 32'(dut.R0), 32'hFF);
        chk("load_e6_ram_addr", 32'(dut.RAM_ADDR), 32'h2);

        // Mid-op reset during DECODE of the LOAD
        load_and_release();
        edges(4);
        chk("midrst_pre_state", 32'(dut.zstate), 32'h1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midrst_pc", 32'(dut.PC), 32'h0);
        chk("midrst_state", 32'(dut.zstate), 32'h0);
        edges(1);
        chk("midrst_r0_held", 32'(dut.R0), 32'h00);
        @(negedge CLK);
        RESET = 1'b1;
        edges(1);
        chk("midrst_e1_ir", 32'(dut.IR), 32'h00);
        chk("midrst_e1_pc", 32'(dut.PC), 32'h1);
        chk("midrst_e1_r0", 32'(dut.R0), 32'h00);
        edges(5);
        chk("midrst_e6_r0", 32'(dut.R0), 32'hFF);

        // JMP at edge 3
        clear_img();
        img[0] = 8'hC5; img[5] = 8'h4F; img[15] = 8'h11;
        load_and_release();
        edges(3);
`ifdef ZEPHYR_JMP_EN
        chk("jmp_e3_pc", 32'(dut.PC), 32'h5);
        edges(3);
        chk("jmp_e6_r0", 32'(dut.R0), 32'h11);
`else
        chk("jmp_e3_pc", 32'(dut.PC), 32'h1);
        edges(3);
        chk("jmp_e6_r0", 32'(dut.R0), 32'h00);
`endif

        // PC wrap over 16 fetches of an all-NOP RAM
        clear_img();
        load_and_release();
        for (int k = 0; k < 16; k++) begin
            edges(1);
            chk($sformatf("wrap_pc_%0d", k), 32'(dut.PC), 32'((k + 1) % 16));
            edges(2);
        end

        // Directed vector table: two instructions each
        for (int v = 0; v < 5; v++) begin
            clear_img();
            img[0] = vecs[v].p0;
            img[1] = vecs[v].p1;
            img[vecs[v].fa] = vecs[v].fv;
            load_and_release();
            edges(6);
            chk($sformatf("vec%0d_reg", v), 32'(reg_of(vecs[v].creg)), 32'(vecs[v].ereg));
            chk($sformatf("vec%0d_mem", v), 32'(dut.ram_inst.registers[vecs[v].caddr]),
                32'(vecs[v].emem));
            chk($sformatf("vec%0d_pc", v), 32'(dut.PC), 32'(vecs[v].epc));
        end

        // Random programs against the reference interpreter
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                img[i] = 8'($urandom);
                m[i] = img[i];
            end
            for (int i = 0; i < 4; i++) r[i] = 8'h00;
            mpc = 4'd0;
            load_and_release();
            for (int n = 0; n < 20; n++) begin
                model_step();
                edges(3);
                chk($sformatf("rnd%0d_%0d_pc", t, n), 32'(dut.PC), 32'(mpc));
                chk($sformatf("rnd%0d_%0d_ram_addr", t, n), 32'(dut.RAM_ADDR), 32'(mpc));
                chk($sformatf("rnd%0d_%0d_state", t, n), 32'(dut.zstate), 32'h0);
                chk($sformatf("rnd%0d_%0d_regs", t, n), {dut.R3, dut.R2, dut.R1, dut.R0},
                    {r[3], r[2], r[1], r[0]});
            end
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("rnd%0d_mem%0d", t, i), 32'(dut.ram_inst.registers[i]), 32'(m[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zephyr.md
# zephyr

Minimal 8-bit multi-cycle accumulator-style CPU core with an embedded 16x8 unified instruction/data RAM. Each instruction takes three states (FETCH, DECODE, EXECUTE). The block has no external data ports: it is top-level self-contained and is observed and preloaded hierarchically by benches (`PC`, `IR`, `RAM_ADDR`, `zstate`, `ram_inst.registers`).

## Interface
- No parameters. Fixed: 8-bit data, 4-bit address, 16-word RAM, 4 general registers R0–R3.
- CLK  input  1  single system clock; all state updates on rising edge.
- RESET  input  1  reset is asynchronous and active-low; asserted (0) forces reset state immediately.
- Required internal names for hierarchical access:
  - `zstate` [1:0]: 00 FETCH, 01 DECODE, 10 EXECUTE.
  - `PC` [3:0].
  - `IR` [7:0].
  - `RAM_ADDR` [3:0].
  - `R0`..`R3` [7:0].
  - RAM instance `ram_inst` with array `registers[0:15]` of [7:0].

## Operation
- Instruction format:
  - [7:6] opcode.
  - [5:4] register index Rd.
  - [3:0] address/immediate A.
- Opcodes:
  - 00 NOP.
  - 01 LOAD: Rd <= mem[A].
  - 10 STORE: mem[A] <= Rd.
  - 11 JMP: PC <= A (see Configuration).
- RAM: asynchronous read of `registers[RAM_ADDR]`; synchronous write on CLK. RAM contents are not cleared by reset.
- Reset values: `PC`=0, `IR`=0x00, `RAM_ADDR`=0, `zstate`=FETCH, R0–R3=0x00.
- FETCH:
  - IR <= mem[RAM_ADDR].
  - PC <= PC+1 (4-bit, 15 wraps to 0).
  - Next state DECODE.
- DECODE:
  - RAM_ADDR <= A for LOAD/STORE; RAM_ADDR <= PC otherwise.
  - Next state EXECUTE.
- EXECUTE:
  - Perform the opcode.
  - RAM_ADDR <= next PC: the JMP target for JMP, the current PC otherwise.
  - Next state FETCH.
- Illegal `zstate` 11 goes to FETCH on the next edge with no side effects.
- STORE to the address of a not-yet-fetched instruction alters that instruction (self-modifying code is allowed).

## Timing
- Every instruction takes exactly 3 cycles. Instruction k (0-based) begins FETCH on rising edge 3k+1 after RESET deassertion.
- Register/memory writeback is visible after the EXECUTE edge.
- PC is visible incremented one cycle after FETCH.
- Asynchronous reset mid-instruction aborts it:
  - No write completes unless its edge preceded reset assertion.
  - After deassertion, execution resumes at address 0 in FETCH on the first rising edge.
- RESET deasserted coincident with a CLK edge: that edge is ignored; the next edge is the first FETCH.

## Configuration
- `ZEPHYR_JMP_EN`, when defined: opcode 11 is JMP, setting PC and RAM_ADDR to A in EXECUTE.
- When not defined: opcode 11 executes as NOP and PC continues sequentially.

## Test plan
- Reset:
  - Stimulus: hold RESET=0 for 2 cycles.
  - Response: PC=0, IR=00, RAM_ADDR=0, `zstate`=FETCH, R0–R3=00.
- Sequence/LOAD:
  - Stimulus: mem[0]=00, mem[1]=0x4F, mem[2]=0x33, mem[3]=0x3F, mem[15]=0xFF; release reset.
  - Edge 1: IR=00, PC=1.
  - Edge 4: IR=4F, PC=2.
  - Edge 5: RAM_ADDR=F.
  - Edge 6: R0=FF, RAM_ADDR=2.
  - States cycle FETCH → DECODE → EXECUTE throughout.
- STORE:
  - Stimulus: mem[0]=0x4E (LOAD R0,14), mem[1]=0x9D (STORE R0,13), mem[14]=0x5A.
  - Response: after edge 6, mem[13]=0x5A and R0=5A.
- JMP (macro defined):
  - Stimulus: mem[0]=0xC5, mem[5]=0x4F, mem[15]=0x11.
  - Response: after edge 3, PC=5; after edge 6, R0=11.
  - Without the macro: PC=1 after edge 3.
- Wrap:
  - Stimulus: all-NOP RAM, run 48 cycles.
  - Response: PC sequence 1..15,0; PC=0 after edge 46 (16th fetch).
- Mid-op reset:
  - Stimulus: assert RESET during DECODE of the LOAD in the LOAD scenario.
  - Response: R0 stays 00; after release, IR=00 and PC=1 at the first edge.
